// File: rtl/axi4_slv_pkg.sv
// Shared encodings for the AXI4 slave memory: burst types, response codes, FSM states.
package axi4_slv_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

endpackage

// File: rtl/axi4_slv_addr_gen.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts; reserved encoding acts as INCR.
module axi4_slv_addr_gen
  import axi4_slv_pkg::*;
#(
  parameter int adr_wid = 32,
  parameter int len_wid = 8
) (
  input  logic [adr_wid-1:0] addr,
  input  logic [2:0]         size,
  input  logic [len_wid-1:0] len,
  input  logic [1:0]         burst,
  output logic [adr_wid-1:0] next_addr
);

  localparam logic [adr_wid-1:0] ONE = adr_wid'(1);

  logic [adr_wid-1:0] incr_addr;
  logic [adr_wid-1:0] wrap_mask;

  always_comb begin
    incr_addr = addr + (ONE << size);
    // Wrap window is (len+1) transfers, aligned to its own size.
    wrap_mask = ((adr_wid'(len) + ONE) << size) - ONE;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by an inferred word memory, with independent write and read FSMs.
// Optional macro AXI_SLV_DECERR_EN: out-of-range words answer DECERR instead of wrapping.
module axi4_slave_mem
  import axi4_slv_pkg::*;
#(
  parameter int data_wid  = 64,
  parameter int adr_wid   = 32,
  parameter int id_wid    = 8,
  parameter int len_wid   = 8,
  parameter int mem_depth = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [id_wid-1:0]     AWID,
  input  logic [adr_wid-1:0]    AWADDR,
  input  logic [len_wid-1:0]    AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic [1:0]            AWBURST,
  input  logic [1:0]            AWLOCK,
  input  logic [1:0]            AWCACHE,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [id_wid-1:0]     WID,
  input  logic [data_wid-1:0]   WDATA,
  input  logic [data_wid/8-1:0] WSTRB,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [id_wid-1:0]     BID,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [id_wid-1:0]     ARID,
  input  logic [adr_wid-1:0]    ARADDR,
  input  logic [len_wid-1:0]    ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic [1:0]            ARLOCK,
  input  logic [1:0]            ARCACHE,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [id_wid-1:0]     RID,
  output logic [data_wid-1:0]   RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int STRB_W   = data_wid / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int MEM_AW   = (mem_depth > 1) ? $clog2(mem_depth) : 1;
  localparam logic [2:0]         MAX_SIZE = 3'(ADDR_LSB);
  localparam logic [adr_wid-1:0] DEPTH_A  = adr_wid'(mem_depth);
  localparam logic [len_wid-1:0] LEN_ONE  = len_wid'(1);
`ifdef AXI_SLV_DECERR_EN
  localparam logic DEC_EN = 1'b1;
`else
  localparam logic DEC_EN = 1'b0;
`endif

  logic [data_wid-1:0] mem [mem_depth];

  logic               rst_done_reg;
  wr_state_t          w_state_reg, w_state_next;
  rd_state_t          r_state_reg, r_state_next;
  logic [id_wid-1:0]  aw_id_reg;
  logic [adr_wid-1:0] aw_addr_reg, ar_addr_reg, w_next_addr, r_next_addr;
  logic [len_wid-1:0] aw_len_reg, ar_len_reg, w_cnt_reg, r_cnt_reg;
  logic [2:0]         aw_size_reg, ar_size_reg;
  logic [1:0]         aw_burst_reg, ar_burst_reg;
  logic               w_err_reg, w_dec_reg, ar_size_err_reg;

  logic unused_sideband;
  assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, ARLOCK, ARCACHE, ARPROT};

  // Ready outputs stay low until the first edge after reset release.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rst_done_reg <= 1'b0;
    else          rst_done_reg <= 1'b1;
  end

  // ---------------- write channel ----------------
  logic               aw_fire, w_fire, w_last_beat, w_beat_err, w_beat_dec, w_we;
  logic [adr_wid-1:0] w_word;
  logic [MEM_AW-1:0]  w_idx;

  assign aw_fire     = AWVALID && AWREADY;
  assign w_fire      = WVALID && WREADY;
  assign w_last_beat = (w_cnt_reg == aw_len_reg) || WLAST;
  assign w_word      = aw_addr_reg >> ADDR_LSB;
  assign w_idx       = MEM_AW'(w_word % DEPTH_A);
  assign w_beat_dec  = DEC_EN && (w_word >= DEPTH_A);
  assign w_beat_err  = (WLAST != (w_cnt_reg == aw_len_reg)) || (WID != aw_id_reg);
  assign w_we        = w_fire && (aw_size_reg <= MAX_SIZE) && !w_beat_dec;

  axi4_slv_addr_gen #(.adr_wid(adr_wid), .len_wid(len_wid)) u_w_addr (
    .addr(aw_addr_reg), .size(aw_size_reg), .len(aw_len_reg),
    .burst(aw_burst_reg), .next_addr(w_next_addr)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state_reg <= W_IDLE;
    else          w_state_reg <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state_reg;
    AWREADY      = 1'b0;
    WREADY       = 1'b0;
    BVALID       = 1'b0;
    case (w_state_reg)
      W_IDLE: begin
        AWREADY = rst_done_reg;
        if (AWVALID && rst_done_reg) w_state_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_last_beat) w_state_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_next = W_IDLE;
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_id_reg    <= '0;
      aw_addr_reg  <= '0;
      aw_len_reg   <= '0;
      aw_size_reg  <= '0;
      aw_burst_reg <= '0;
      w_cnt_reg    <= '0;
      w_err_reg    <= 1'b0;
      w_dec_reg    <= 1'b0;
      BID          <= '0;
      BRESP        <= RESP_OKAY;
    end else if (aw_fire) begin
      aw_id_reg    <= AWID;
      aw_addr_reg  <= AWADDR;
      aw_len_reg   <= AWLEN;
      aw_size_reg  <= AWSIZE;
      aw_burst_reg <= AWBURST;
      w_cnt_reg    <= '0;
      w_err_reg    <= (AWSIZE > MAX_SIZE);
      w_dec_reg    <= 1'b0;
    end else if (w_fire) begin
      aw_addr_reg <= w_next_addr;
      w_cnt_reg   <= w_cnt_reg + LEN_ONE;
      w_err_reg   <= w_err_reg || w_beat_err;
      w_dec_reg   <= w_dec_reg || w_beat_dec;
      if (w_last_beat) begin
        BID   <= aw_id_reg;
        BRESP <= (w_dec_reg || w_beat_dec) ? RESP_DECERR :
                 (w_err_reg || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge ACLK) begin
    if (w_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (WSTRB[i]) mem[w_idx][i*8 +: 8] <= WDATA[i*8 +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  logic               ar_fire, r_fire, r_sel_size_err, r_beat_dec;
  logic [adr_wid-1:0] r_sel_addr, r_word;
  logic [MEM_AW-1:0]  r_idx;
  logic [1:0]         r_beat_resp;

  axi4_slv_addr_gen #(.adr_wid(adr_wid), .len_wid(len_wid)) u_r_addr (
    .addr(ar_addr_reg), .size(ar_size_reg), .len(ar_len_reg),
    .burst(ar_burst_reg), .next_addr(r_next_addr)
  );

  // One shared read port: AR address when idle, otherwise the following beat.
  assign ar_fire        = ARVALID && ARREADY;
  assign r_fire         = RVALID && RREADY;
  assign r_sel_addr     = (r_state_reg == R_IDLE) ? ARADDR : r_next_addr;
  assign r_sel_size_err = (r_state_reg == R_IDLE) ? (ARSIZE > MAX_SIZE) : ar_size_err_reg;
  assign r_word         = r_sel_addr >> ADDR_LSB;
  assign r_idx          = MEM_AW'(r_word % DEPTH_A);
  assign r_beat_dec     = DEC_EN && (r_word >= DEPTH_A);
  assign r_beat_resp    = r_beat_dec ? RESP_DECERR : (r_sel_size_err ? RESP_SLVERR : RESP_OKAY);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state_reg <= R_IDLE;
    else          r_state_reg <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state_reg;
    ARREADY      = 1'b0;
    RVALID       = 1'b0;
    case (r_state_reg)
      R_IDLE: begin
        ARREADY = rst_done_reg;
        if (ARVALID && rst_done_reg) r_state_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && RLAST) r_state_next = R_IDLE;
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ar_addr_reg     <= '0;
      ar_len_reg      <= '0;
      ar_size_reg     <= '0;
      ar_burst_reg    <= '0;
      ar_size_err_reg <= 1'b0;
      r_cnt_reg       <= '0;
      RID             <= '0;
      RDATA           <= '0;
      RRESP           <= RESP_OKAY;
      RLAST           <= 1'b0;
    end else if (ar_fire) begin
      ar_addr_reg     <= ARADDR;
      ar_len_reg      <= ARLEN;
      ar_size_reg     <= ARSIZE;
      ar_burst_reg    <= ARBURST;
      ar_size_err_reg <= (ARSIZE > MAX_SIZE);
      r_cnt_reg       <= '0;
      RID             <= ARID;
      RDATA           <= (r_beat_resp == RESP_OKAY) ? mem[r_idx] : '0;
      RRESP           <= r_beat_resp;
      RLAST           <= (ARLEN == '0);
    end else if (r_fire) begin
      if (RLAST) begin
        RLAST <= 1'b0;
      end else begin
        ar_addr_reg <= r_next_addr;
        r_cnt_reg   <= r_cnt_reg + LEN_ONE;
        RDATA       <= (r_beat_resp == RESP_OKAY) ? mem[r_idx] : '0;
        RRESP       <= r_beat_resp;
        RLAST       <= ((r_cnt_reg + LEN_ONE) == ar_len_reg);
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Directed bench for axi4_slave_mem: INCR/WRAP/FIXED bursts, early WLAST, RREADY stall,
// strobes, oversize, address wrap/DECERR (follows AXI_SLV_DECERR_EN) and mid-burst reset.
module tb_axi4_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [7:0]  AWID = '0, WID = '0, BID, ARID = '0, RID;
  logic [31:0] AWADDR = '0, ARADDR = '0;
  logic [7:0]  AWLEN = '0, ARLEN = '0;
  logic [2:0]  AWSIZE = '0, ARSIZE = '0, AWPROT = '0, ARPROT = '0;
  logic [1:0]  AWBURST = '0, ARBURST = '0, AWLOCK = '0, ARLOCK = '0, AWCACHE = '0, ARCACHE = '0;
  logic        AWVALID = 1'b0, AWREADY, WLAST = 1'b0, WVALID = 1'b0, WREADY;
  logic [63:0] WDATA = '0, RDATA;
  logic [7:0]  WSTRB = '0;
  logic [1:0]  BRESP, RRESP;
  logic        BVALID, BREADY = 1'b0, ARVALID = 1'b0, ARREADY;
  logic        RLAST, RVALID, RREADY = 1'b0;

  axi4_slave_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  int   tests = 0;
  int   failed = 0;
  logic to_flag = 1'b0;

  logic [63:0] wdat [16];
  logic [7:0]  wstrb [16];
  logic [63:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [7:0]  rd_id [16];
  logic [7:0]  b_id;
  logic [1:0]  b_resp;

  // All handshake tasks start and finish 1 time unit after a rising edge.
  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    while (AWREADY !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) to_flag = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [7:0] id, input int nbeats);
    int n;
    for (int i = 0; i < nbeats; i++) begin
      WID = id; WDATA = wdat[i]; WSTRB = wstrb[i]; WLAST = (i == nbeats - 1); WVALID = 1'b1;
      n = 0;
      while (WREADY !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
      if (n >= 50) to_flag = 1'b1;
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic do_b();
    int n = 0;
    BREADY = 1'b1;
    while (BVALID !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) to_flag = 1'b1;
    b_id = BID; b_resp = BRESP;
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
    while (ARREADY !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) to_flag = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
  endtask

  task automatic do_r(input int nbeats);
    int n;
    RREADY = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      n = 0;
      while (RVALID !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
      if (n >= 50) to_flag = 1'b1;
      rd_data[i] = RDATA; rd_last[i] = RLAST; rd_resp[i] = RRESP; rd_id[i] = RID;
      @(posedge ACLK); #1;
    end
    RREADY = 1'b0;
  endtask

  task automatic check_timeout(input string name);
    tests++;
    if (to_flag !== 1'b0) begin
      failed++;
      $display("FAIL %s_timeout got 1 exp 0", name);
    end
    to_flag = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge ACLK); #1; @(posedge ACLK); #1;
    tests++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST} !== 6'b0) begin
      failed++; $display("FAIL reset_ctrl got %b exp 000000", {AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST});
    end
    tests++;
    if ({BID, RID, BRESP, RRESP, RDATA} !== '0) begin
      failed++; $display("FAIL reset_data got %h exp 0", {BID, RID, BRESP, RRESP, RDATA});
    end
    ARESETn = 1'b1;
    #1;
    tests++;
    if (AWREADY !== 1'b0) begin failed++; $display("FAIL reset_awready_pre_edge got %b exp 0", AWREADY); end
    @(posedge ACLK); #1;
    tests++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      failed++; $display("FAIL reset_ready_after_edge got %b exp 11", {AWREADY, ARREADY});
    end
    $display("[TB] reset: done");
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'h11 * (i + 1); wstrb[i] = 8'hFF; end
    do_aw(8'h5A, 32'h0, 8'd3, 3'd3, 2'b01); do_w(8'h5A, 4); do_b();
    tests++;
    if ({b_id, b_resp} !== {8'h5A, 2'b00}) begin
      failed++; $display("FAIL incr_b got id=%h resp=%b exp id=5a resp=00", b_id, b_resp);
    end
    do_ar(8'h3C, 32'h0, 8'd3, 3'd3, 2'b01); do_r(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_data[i] !== 64'h11 * (i + 1) || rd_last[i] !== (i == 3) || rd_resp[i] !== 2'b00 || rd_id[i] !== 8'h3C) begin
        failed++;
        $display("FAIL incr_r[%0d] got data=%h last=%b resp=%b id=%h exp data=%h last=%b resp=00 id=3c",
                 i, rd_data[i], rd_last[i], rd_resp[i], rd_id[i], 64'h11 * (i + 1), (i == 3));
      end
    end
    check_timeout("incr");
    $display("[TB] incr: write+read 4 beats at 0x0");
  endtask

  task automatic test_wrap();
    logic [63:0] exp_w [4];
    for (int i = 0; i < 4; i++) begin wdat[i] = 64'hA0 + i; wstrb[i] = 8'hFF; end
    do_aw(8'h01, 32'h18, 8'd3, 3'd3, 2'b10); do_w(8'h01, 4); do_b();
    tests++;
    if (b_resp !== 2'b00) begin failed++; $display("FAIL wrap_bresp got %b exp 00", b_resp); end
    do_ar(8'h02, 32'h18, 8'd3, 3'd3, 2'b10); do_r(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_data[i] !== 64'hA0 + i || rd_last[i] !== (i == 3)) begin
        failed++; $display("FAIL wrap_r[%0d] got %h last=%b exp %h", i, rd_data[i], rd_last[i], 64'hA0 + i);
      end
    end
    // Words 3,0,1,2 received A0..A3, so linear order is A1,A2,A3,A0.
    exp_w[0] = 64'hA1; exp_w[1] = 64'hA2; exp_w[2] = 64'hA3; exp_w[3] = 64'hA0;
    do_ar(8'h03, 32'h0, 8'd3, 3'd3, 2'b01); do_r(4);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (rd_data[i] !== exp_w[i]) begin
        failed++; $display("FAIL wrap_linear[%0d] got %h exp %h", i, rd_data[i], exp_w[i]);
      end
    end
    check_timeout("wrap");
    $display("[TB] wrap: 0x18 len3 -> words 3,0,1,2");
  endtask

  task automatic test_early_wlast();
    wdat[0] = 64'hB0; wdat[1] = 64'hB1; wstrb[0] = 8'hFF; wstrb[1] = 8'hFF;
    do_aw(8'h44, 32'h40, 8'd3, 3'd3, 2'b01); do_w(8'h44, 2);
    tests++;
    if (WREADY !== 1'b0) begin failed++; $display("FAIL early_wready got %b exp 0", WREADY); end
    do_b();
    tests++;
    if ({b_id, b_resp} !== {8'h44, 2'b10}) begin
      failed++; $display("FAIL early_b got id=%h resp=%b exp id=44 resp=10", b_id, b_resp);
    end
    tests++;
    if (AWREADY !== 1'b1) begin failed++; $display("FAIL early_idle got %b exp 1", AWREADY); end
    wdat[0] = 64'h55;
    do_aw(8'h45, 32'h40, 8'd0, 3'd3, 2'b01); do_w(8'h45, 1); do_b();
    tests++;
    if (b_resp !== 2'b00) begin failed++; $display("FAIL early_next_bresp got %b exp 00", b_resp); end
    do_ar(8'h46, 32'h40, 8'd1, 3'd3, 2'b01); do_r(2);
    tests++;
    if (rd_data[0] !== 64'h55 || rd_data[1] !== 64'hB1) begin
      failed++; $display("FAIL early_mem got %h,%h exp 55,b1", rd_data[0], rd_data[1]);
    end
    check_timeout("early_wlast");
    $display("[TB] early_wlast: SLVERR then OKAY");
  endtask

  task automatic test_rready_stall();
    int n = 0;
    do_ar(8'h21, 32'h0, 8'd3, 3'd3, 2'b01);
    RREADY = 1'b1;
    while (RVALID !== 1'b1 && n < 50) begin @(posedge ACLK); #1; n++; end
    if (n >= 50) to_flag = 1'b1;
    tests++;
    if (RDATA !== 64'hA1) begin failed++; $display("FAIL stall_beat0 got %h exp a1", RDATA); end
    @(posedge ACLK); #1;
    RREADY = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tests++;
      if (RVALID !== 1'b1 || RDATA !== 64'hA2 || RLAST !== 1'b0 || RID !== 8'h21) begin
        failed++; $display("FAIL stall_hold[%0d] got v=%b d=%h l=%b id=%h exp v=1 d=a2 l=0 id=21", c, RVALID, RDATA, RLAST, RID);
      end
      @(posedge ACLK); #1;
    end
    do_r(3);
    tests++;
    if (rd_data[0] !== 64'hA2 || rd_data[1] !== 64'hA3 || rd_data[2] !== 64'hA0 ||
        {rd_last[0], rd_last[1], rd_last[2]} !== 3'b001) begin
      failed++; $display("FAIL stall_rest got %h,%h,%h last=%b%b%b exp a2,a3,a0 last=001",
                         rd_data[0], rd_data[1], rd_data[2], rd_last[0], rd_last[1], rd_last[2]);
    end
    check_timeout("rready_stall");
    $display("[TB] rready_stall: 5-cycle hold");
  endtask

  task automatic test_strb_fixed();
    wdat[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb[0] = 8'hFF;
    wdat[1] = 64'h1122_3344_5566_7788; wstrb[1] = 8'h0F;
    do_aw(8'h07, 32'h20, 8'd1, 3'd3, 2'b00); do_w(8'h07, 2); do_b();
    do_ar(8'h08, 32'h20, 8'd0, 3'd3, 2'b01); do_r(1);
    tests++;
    if (b_resp !== 2'b00 || rd_data[0] !== 64'hFFFF_FFFF_5566_7788) begin
      failed++; $display("FAIL strb_fixed got resp=%b data=%h exp resp=00 data=ffffffff55667788", b_resp, rd_data[0]);
    end
    check_timeout("strb_fixed");
    $display("[TB] strb_fixed: partial strobe on one word");
  endtask

  task automatic test_size_err();
    wdat[0] = 64'h0; wstrb[0] = 8'hFF;
    do_aw(8'h09, 32'h20, 8'd0, 3'd4, 2'b01); do_w(8'h09, 1); do_b();
    tests++;
    if (b_resp !== 2'b10) begin failed++; $display("FAIL size_bresp got %b exp 10", b_resp); end
    do_ar(8'h0A, 32'h20, 8'd0, 3'd3, 2'b01); do_r(1);
    tests++;
    if (rd_data[0] !== 64'hFFFF_FFFF_5566_7788) begin
      failed++; $display("FAIL size_mem got %h exp ffffffff55667788", rd_data[0]);
    end
    do_ar(8'h0B, 32'h20, 8'd0, 3'd4, 2'b01); do_r(1);
    tests++;
    if (rd_resp[0] !== 2'b10) begin failed++; $display("FAIL size_rresp got %b exp 10", rd_resp[0]); end
    check_timeout("size_err");
    $display("[TB] size_err: oversize write/read");
  endtask

  task automatic test_addr_range();
    wdat[0] = 64'h77; wstrb[0] = 8'hFF;
    do_aw(8'h0C, 32'h800, 8'd0, 3'd3, 2'b01); do_w(8'h0C, 1); do_b();
`ifdef AXI_SLV_DECERR_EN
    tests++;
    if (b_resp !== 2'b11) begin failed++; $display("FAIL range_bresp got %b exp 11", b_resp); end
    do_ar(8'h0D, 32'h800, 8'd0, 3'd3, 2'b01); do_r(1);
    tests++;
    if (rd_resp[0] !== 2'b11 || rd_data[0] !== 64'h0) begin
      failed++; $display("FAIL range_r got resp=%b data=%h exp resp=11 data=0", rd_resp[0], rd_data[0]);
    end
    do_ar(8'h0E, 32'h0, 8'd0, 3'd3, 2'b01); do_r(1);
    tests++;
    if (rd_data[0] !== 64'hA1) begin failed++; $display("FAIL range_word0 got %h exp a1", rd_data[0]); end
`else
    tests++;
    if (b_resp !== 2'b00) begin failed++; $display("FAIL range_bresp got %b exp 00", b_resp); end
    do_ar(8'h0E, 32'h0, 8'd0, 3'd3, 2'b01); do_r(1);
    tests++;
    if (rd_data[0] !== 64'h77 || rd_resp[0] !== 2'b00) begin
      failed++; $display("FAIL range_word0 got %h resp=%b exp 77 resp=00", rd_data[0], rd_resp[0]);
    end
`endif
    check_timeout("addr_range");
    $display("[TB] addr_range: write at word 256");
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    wdat[0] = 64'hC0; wdat[1] = 64'hC1; wstrb[0] = 8'hFF; wstrb[1] = 8'hFF;
    do_aw(8'h66, 32'h60, 8'd3, 3'd3, 2'b01);
    for (int i = 0; i < 2; i++) begin
      WID = 8'h66; WDATA = wdat[i]; WSTRB = 8'hFF; WLAST = 1'b0; WVALID = 1'b1;
      @(posedge ACLK); #1;
    end
    WDATA = 64'hC2;
    ARESETn = 1'b0;
    #1;
    tests++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST} !== 6'b0 || {BID, RID, BRESP, RRESP, RDATA} !== '0) begin
      failed++; $display("FAIL midrst_outputs got ctrl=%b data=%h exp 0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST},
                         {BID, RID, BRESP, RRESP, RDATA});
    end
    WVALID = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    #1;
    tests++;
    if (AWREADY !== 1'b0) begin failed++; $display("FAIL midrst_pre_edge got %b exp 0", AWREADY); end
    @(posedge ACLK); #1;
    tests++;
    if (AWREADY !== 1'b1) begin failed++; $display("FAIL midrst_awready got %b exp 1", AWREADY); end
    BREADY = 1'b1;
    while (n < 3) begin
      if (BVALID !== 1'b0) to_flag = 1'b1;
      @(posedge ACLK); #1; n++;
    end
    BREADY = 1'b0;
    tests++;
    if (to_flag !== 1'b0) begin failed++; $display("FAIL midrst_no_b got bvalid seen exp none"); end
    to_flag = 1'b0;
    do_ar(8'h67, 32'h60, 8'd1, 3'd3, 2'b01); do_r(2);
    tests++;
    if (rd_data[0] !== 64'hC0 || rd_data[1] !== 64'hC1) begin
      failed++; $display("FAIL midrst_mem got %h,%h exp c0,c1", rd_data[0], rd_data[1]);
    end
    check_timeout("reset_mid_burst");
    $display("[TB] reset_mid_burst: burst aborted, beats kept");
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_early_wlast();
    test_rready_stall();
    test_strb_fixed();
    test_size_err();
    test_addr_range();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mem.md
AXI4_SLAVE_MEM -- requirements
Module: axi4_slave_mem

Interface
REQ-001 SHALL have parameter data_wid, default 64, meaning R/W data width in bits.
REQ-002 SHALL have parameter adr_wid, default 32, meaning address width.
REQ-003 SHALL have parameter id_wid, default 8, meaning transaction ID width.
REQ-004 SHALL have parameter len_wid, default 8, meaning burst length field width.
REQ-005 SHALL have parameter mem_depth, default 256, meaning number of data_wid-bit memory words.
REQ-006 SHALL have port ACLK, in, 1, sole clock; one clock; all logic rising-edge.
REQ-007 SHALL have port ARESETn, in, 1, reset, asynchronous, active-low.
REQ-008 SHALL have AW ports: AWID in id_wid, AWADDR in adr_wid, AWLEN in len_wid, AWSIZE in 3, AWBURST in 2, AWLOCK in 2, AWCACHE in 2, AWPROT in 3, AWVALID in 1, AWREADY out 1.
REQ-009 SHALL have W ports: WID in id_wid, WDATA in data_wid, WSTRB in data_wid/8, WLAST in 1, WVALID in 1, WREADY out 1.
REQ-010 SHALL have B ports: BID out id_wid, BRESP out 2, BVALID out 1, BREADY in 1.
REQ-011 SHALL have AR ports mirroring AW (ARID..ARPROT, ARVALID in, ARREADY out).
REQ-012 SHALL have R ports: RID out id_wid, RDATA out data_wid, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1.

Function
REQ-013 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE; AW handshake latches ID/addr/len/size/burst, goes W_DATA.
REQ-014 In W_DATA, WREADY=1; each W handshake SHALL write bytes with WSTRB[i]=1 into word addr[..log2(data_wid/8)] in the same edge, then advance address.
REQ-015 On the handshake where beat count equals AWLEN, or WLAST=1, FSM SHALL go W_RESP; BVALID=1, BID=latched AWID, held until BREADY; then W_IDLE.
REQ-016 BRESP SHALL be SLVERR (2'b10) if WLAST position mismatches AWLEN+1 beats or WID differs from AWID, else OKAY; W beats after early termination not accepted.
REQ-017 Read FSM SHALL use R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; first RVALID in the cycle after AR handshake.
REQ-018 RDATA SHALL be registered full-word memory contents; RVALID/RDATA/RID/RRESP/RLAST SHALL hold stable while RVALID=1 and RREADY=0.
REQ-019 RLAST SHALL be 1 exactly on beat ARLEN (ARLEN+1 beats); after its handshake FSM returns R_IDLE.
REQ-020 Next address: FIXED (2'b00) unchanged; INCR (2'b01) +2^size; WRAP (2'b10) +2^size wrapping within (len+1)*2^size aligned boundary; reserved (2'b11) treated as INCR.
REQ-021 AxSIZE above log2(data_wid/8) SHALL yield SLVERR for the whole burst; memory unmodified.
REQ-022 Read and write channels SHALL operate concurrently; same-word same-cycle collision returns pre-write data.
REQ-023 AxLOCK, AxCACHE, AxPROT SHALL be accepted and ignored.

Reset
REQ-024 ARESETn low SHALL force W_IDLE, R_IDLE, AWREADY/WREADY/ARREADY/BVALID/RVALID/RLAST=0, BID/RID/BRESP/RRESP/RDATA=0.
REQ-025 AWREADY and ARREADY SHALL assert on the first edge after ARESETn deasserts.
REQ-026 Reset mid-burst SHALL abort the burst with no response; memory contents SHALL NOT be reset.

Configuration
REQ-027 With AXI_SLV_DECERR_EN defined, any beat whose word index is >= mem_depth SHALL give DECERR (2'b11) (burst-level for B, per-beat for R, RDATA=0) and not write memory; DECERR outranks SLVERR.
REQ-028 Without AXI_SLV_DECERR_EN, word index SHALL wrap modulo mem_depth and no DECERR is ever produced.

Structure
REQ-029 Package axi4_slv_pkg SHALL hold burst encodings, response codes, and write/read FSM state enums.
REQ-030 Next-address logic SHALL be sub-module axi4_slv_addr_gen, instantiated once per channel.

Verification
REQ-031 AW INCR addr 0x0, len 3, size 3, WDATA 0x11..0x44, WSTRB 0xFF -> BRESP OKAY, BID=AWID; AR same -> RDATA 0x11,0x22,0x33,0x44, RLAST on 4th.
REQ-032 WRAP addr 0x18, len 3, size 3 -> writes words 3,0,1,2; readback order matches.
REQ-033 WLAST on beat 2 of len 3 -> BRESP SLVERR, FSM back to W_IDLE, next burst OKAY.
REQ-034 RREADY held low 5 cycles mid-burst -> RDATA/RLAST stable, no beat lost.
REQ-035 Address 0x800 (word 256) with AXI_SLV_DECERR_EN -> BRESP DECERR; without -> word 0 written, OKAY.
REQ-036 ARESETn low during W_DATA beat 2 -> all outputs reset values, AWREADY=1 next edge after release, earlier beats retained.
